// File: rtl/burst_replay_buffer.sv
// Burst capture-and-replay buffer: stores one contiguous input burst in a
// single-port RAM, then replays it forward or reverse under output backpressure.
module burst_replay_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              mode_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              overflow_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   rdCnt_q;
    logic              mode_q;
    logic              overflow_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ramRdData_q;
    logic              rdValid_q;
    logic              rdLast_q;

    logic              headValid_q;
    logic              headLast_q;
    logic [DATA_W-1:0] headData_q;
    logic              skidValid_q;
    logic              skidLast_q;
    logic [DATA_W-1:0] skidData_q;

    logic              ramWe;
    logic              ramRe;
    logic [ADDR_W-1:0] ramAddr;
    logic              pop;
    logic [1:0]        occ;
    logic [ADDR_W:0]   revAddr;
    logic              issueRd;
    logic              rdLast_d;

    // A read may only be issued if its data is guaranteed a slot in the
    // head/skid pair even when the consumer stalls from now on.
    always_comb begin
        ramWe    = 1'b0;
        ramRe    = 1'b0;
        ramAddr  = '0;
        pop      = headValid_q && out_ready_i;
        occ      = 2'(headValid_q) + 2'(skidValid_q) + 2'(rdValid_q);
        revAddr  = count_q - rdCnt_q - CNT_ONE;
        rdLast_d = (rdCnt_q == (count_q - CNT_ONE));
        issueRd  = (state_q == DRAIN) && (rdCnt_q < count_q) &&
                   (occ <= (pop ? 2'd2 : 2'd1));
        case (state_q)
            IDLE: begin
                ramWe = in_valid_i;
            end
            LOAD: begin
                ramWe   = in_valid_i && (count_q < DEPTH_CNT);
                ramAddr = count_q[ADDR_W-1:0];
            end
            DRAIN: begin
                ramRe   = issueRd;
                ramAddr = mode_q ? revAddr[ADDR_W-1:0] : rdCnt_q[ADDR_W-1:0];
            end
            default: begin
                ramAddr = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (ramWe) begin
            mem[ramAddr] <= in_data_i;
        end else if (ramRe) begin
            ramRdData_q <= mem[ramAddr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rdCnt_q     <= '0;
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            rdValid_q   <= 1'b0;
            rdLast_q    <= 1'b0;
            headValid_q <= 1'b0;
            headLast_q  <= 1'b0;
            headData_q  <= '0;
            skidValid_q <= 1'b0;
            skidLast_q  <= 1'b0;
            skidData_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= LOAD;
                        count_q    <= CNT_ONE;
                        rdCnt_q    <= '0;
                        mode_q     <= mode_i;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        if (count_q < DEPTH_CNT) begin
                            count_q <= count_q + CNT_ONE;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    rdValid_q <= issueRd;
                    rdLast_q  <= issueRd && rdLast_d;
                    if (issueRd) begin
                        rdCnt_q <= rdCnt_q + CNT_ONE;
                    end
                    // Ordering is head, then skid, then the RAM data in flight.
                    if (pop) begin
                        if (skidValid_q) begin
                            headValid_q <= 1'b1;
                            headData_q  <= skidData_q;
                            headLast_q  <= skidLast_q;
                            skidValid_q <= rdValid_q;
                            skidData_q  <= rdValid_q ? ramRdData_q : '0;
                            skidLast_q  <= rdValid_q && rdLast_q;
                        end else begin
                            headValid_q <= rdValid_q;
                            headData_q  <= rdValid_q ? ramRdData_q : '0;
                            headLast_q  <= rdValid_q && rdLast_q;
                        end
                    end else if (rdValid_q) begin
                        if (!headValid_q) begin
                            headValid_q <= 1'b1;
                            headData_q  <= ramRdData_q;
                            headLast_q  <= rdLast_q;
                        end else begin
                            skidValid_q <= 1'b1;
                            skidData_q  <= ramRdData_q;
                            skidLast_q  <= rdLast_q;
                        end
                    end
                    if (pop && headLast_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                        rdCnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = headValid_q;
    assign out_data_o  = headData_q;
    assign out_last_o  = headLast_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_burst_replay_buffer.sv
// Scoreboard bench for burst_replay_buffer: stimulus pushes expected beats,
// an independent monitor pops and compares every accepted output beat.
module tb_burst_replay_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inValid = 1'b0;
    logic [DATA_W-1:0] inData = '0;
    logic              modeSel = 1'b0;
    logic              outReady = 1'b1;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic              outLast;
    logic              overflowFlag;
    logic              busy;

    int                total = 0;
    int                bad = 0;
    int                acceptCount = 0;
    int                expCount = 0;
    beat_t             sbQueue[$];
    logic [DATA_W-1:0] stimBuf [16];
    logic              bpEnable = 1'b0;
    logic [15:0]       bpPattern = 16'b0110_0011_1001_0101;
    int                bpIdx = 0;

    burst_replay_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (inValid),
        .in_data_i  (inData),
        .mode_i     (modeSel),
        .out_ready_i(outReady),
        .out_valid_o(outValid),
        .out_data_o (outData),
        .out_last_o (outLast),
        .overflow_o (overflowFlag),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Overflow state after sample idx has been sampled; the edge of the first
    // dropped sample itself is left unchecked.
    task automatic checkOverflowAfter(input int idx);
        if (idx < DEPTH) begin
            checkOutput("overflowLow", 32'(overflowFlag), 32'd0);
        end else if (idx > DEPTH) begin
            checkOutput("overflowHigh", 32'(overflowFlag), 32'd1);
        end
    endtask

    task automatic applyStimulus(input int len, input logic modeBit, input logic toggleMode);
        int stored;
        int idx;
        beat_t b;
        stored = (len < DEPTH) ? len : DEPTH;
        for (int k = 0; k < stored; k++) begin
            idx    = modeBit ? (stored - 1 - k) : k;
            b.data = stimBuf[idx];
            b.last = (k == stored - 1);
            sbQueue.push_back(b);
        end
        expCount    = stored;
        acceptCount = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            if (i >= 1) begin
                checkOverflowAfter(i - 1);
            end
            inValid = 1'b1;
            inData  = stimBuf[i];
            modeSel = (i != 0 && toggleMode) ? ~modeBit : modeBit;
        end
        @(posedge clk);
        #1;
        checkOverflowAfter(len - 1);
        inValid = 1'b0;
        inData  = '0;
    endtask

    task automatic waitDrain();
        int c;
        c = 0;
        while (busy && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drainDone", 32'(busy), 32'd0);
        checkOutput("beatCount", 32'(acceptCount), 32'(expCount));
        checkOutput("sbEmpty", 32'(sbQueue.size()), 32'd0);
    endtask

    task automatic fillRamp(input logic [DATA_W-1:0] start, input int len);
        for (int i = 0; i < len; i++) begin
            stimBuf[i] = start + DATA_W'(i);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bpEnable) begin
                outReady = bpPattern[bpIdx % 16];
                bpIdx++;
            end else begin
                outReady = 1'b1;
            end
        end
    end

    // Monitor: compares accepted beats against the scoreboard and checks
    // that a stalled beat is held unchanged.
    initial begin
        beat_t             expBeat;
        logic              prevStall;
        logic [DATA_W-1:0] prevData;
        logic              prevLast;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stallValid", 32'(outValid), 32'd1);
                    checkOutput("stallData", 32'(outData), 32'(prevData));
                    checkOutput("stallLast", 32'(outLast), 32'(prevLast));
                end
                if (!outValid) begin
                    checkOutput("idleDataZero", 32'(outData), 32'd0);
                    checkOutput("idleLastZero", 32'(outLast), 32'd0);
                end
                if (outValid && outReady) begin
                    acceptCount++;
                    if (sbQueue.size() == 0) begin
                        checkOutput("unexpectedBeat", 32'(sbQueue.size()), 32'd1);
                    end else begin
                        expBeat = sbQueue.pop_front();
                        checkOutput("beatData", 32'(outData), 32'(expBeat.data));
                        checkOutput("beatLast", 32'(outLast), 32'(expBeat.last));
                    end
                end
                prevStall = outValid && !outReady;
                prevData  = outData;
                prevLast  = outLast;
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstData", 32'(outData), 32'd0);
        checkOutput("rstLast", 32'(outLast), 32'd0);
        checkOutput("rstOverflow", 32'(overflowFlag), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        rst = 1'b0;

        $display("[TB] forward burst with latency checks");
        stimBuf[0] = 16'h0011;
        stimBuf[1] = 16'h0022;
        stimBuf[2] = 16'h0033;
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("busyDuringLoad", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("validAtE1", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("validAtE2", 32'(outValid), 32'd1);
        checkOutput("dataAtE2", 32'(outData), 32'h0011);
        @(posedge clk);
        #1;
        checkOutput("dataAtE3", 32'(outData), 32'h0022);
        checkOutput("lastAtE3", 32'(outLast), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("dataAtE4", 32'(outData), 32'h0033);
        checkOutput("lastAtE4", 32'(outLast), 32'd1);
        checkOutput("busyAtE4", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("busyFallE5", 32'(busy), 32'd0);
        checkOutput("validFallE5", 32'(outValid), 32'd0);
        waitDrain();

        $display("[TB] reverse burst with mode toggled mid-burst");
        fillRamp(16'd1, 5);
        applyStimulus(5, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] backpressure burst");
        fillRamp(16'h0010, 8);
        bpEnable = 1'b1;
        applyStimulus(8, 1'b0, 1'b0);
        waitDrain();
        bpEnable = 1'b0;

        $display("[TB] overflow burst");
        fillRamp(16'h00A0, 11);
        applyStimulus(11, 1'b0, 1'b0);
        waitDrain();
        checkOutput("overflowHeld", 32'(overflowFlag), 32'd1);

        $display("[TB] single-sample burst");
        stimBuf[0] = 16'hBEEF;
        applyStimulus(1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] input pulse during drain");
        fillRamp(16'h0030, 5);
        applyStimulus(5, 1'b0, 1'b0);
        c = 0;
        while (!outValid && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drainStarted", 32'(outValid), 32'd1);
        inValid = 1'b1;
        inData  = 16'hDEAD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inData  = '0;
        waitDrain();
        fillRamp(16'h0040, 3);
        applyStimulus(3, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] reset during drain");
        fillRamp(16'h0060, 6);
        applyStimulus(6, 1'b0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (acceptCount >= 2) break;
        end
        #1;
        checkOutput("thirdBeatShown", 32'(outData), 32'h0062);
        rst = 1'b1;
        sbQueue.delete();
        @(posedge clk);
        #1;
        checkOutput("midRstValid", 32'(outValid), 32'd0);
        checkOutput("midRstData", 32'(outData), 32'd0);
        checkOutput("midRstLast", 32'(outLast), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstOverflow", 32'(overflowFlag), 32'd0);
        rst = 1'b0;
        fillRamp(16'h0070, 4);
        applyStimulus(4, 1'b0, 1'b0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
